// File: rtl/sigma_delta_sample_sequencer_pkg.sv
// Shared types for the sigma-delta sample sequencer: FSM state encoding and ramp step scaling.
package sigma_delta_sample_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, RAMP} state_e;

  // Soft-mute step is midscale shifted down by this amount (1 << (MSBI-7)).
  localparam int RAMP_SHIFT = 7;

endpackage

// File: rtl/stereo_sample_fifo.sv
// Synchronous stereo-pair FIFO with registered level, full and empty flags.
module stereo_sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign rdata = mem[rptr];

  always_ff @(posedge CLK)
    if (push) mem[wptr] <= wdata;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      // Simultaneous push and pop leave level and flags untouched.
      case ({push, pop})
        2'b10: begin
          level <= level + 1'b1;
          full  <= (level == LAST);
          empty <= 1'b0;
        end
        2'b01: begin
          level <= level - 1'b1;
          full  <= 1'b0;
          empty <= (level == ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sigma_delta_sample_sequencer.sv
// Paces stereo PCM pairs from a FIFO into two sigma-delta DACs at a programmable sample period.
// Optional soft-mute ramp toward midscale on disable: define DAC_SOFT_MUTE_EN.
module sigma_delta_sample_sequencer
  import sigma_delta_sample_sequencer_pkg::*;
#(
  parameter int MSBI       = 15,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 12
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ENABLE,
  input  logic [DIV_W-1:0]            RATE_DIV,
  input  logic [MSBI:0]               SAMPLE_L,
  input  logic [MSBI:0]               SAMPLE_R,
  input  logic                        SAMPLE_VALID,
  output logic                        SAMPLE_READY,
  output logic [MSBI:0]               DAC_L,
  output logic [MSBI:0]               DAC_R,
  output logic                        SAMPLE_STROBE,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        UNDERRUN,
  input  logic                        UNDERRUN_CLR
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [MSBI:0]  MID  = {1'b1, {MSBI{1'b0}}};
  localparam logic [LW-1:0]  HALF = LW'(FIFO_DEPTH / 2);

  typedef struct packed {
    logic [MSBI:0] l;
    logic [MSBI:0] r;
  } pair_t;

`ifdef DAC_SOFT_MUTE_EN
  localparam state_e OFF = RAMP;
  localparam logic [MSBI:0] STEP = MID >> RAMP_SHIFT;
  logic ramp_tick;

  function automatic logic [MSBI:0] ramp_step(input logic [MSBI:0] d);
    logic [MSBI:0] diff;
    diff = (d > MID) ? d - MID : MID - d;
    if (diff > STEP) diff = STEP;
    return (d > MID) ? d - diff : d + diff;
  endfunction
`else
  localparam state_e OFF = IDLE;
`endif

  state_e           state, state_nxt;
  logic [DIV_W-1:0] div;
  logic             div_zero, push, pop, underrun_set, fifo_full, fifo_empty;
  pair_t            wr_pair, rd_pair;

  // Two's complement to excess-2**MSBI is just an MSB flip.
  function automatic logic [MSBI:0] excess(input logic [MSBI:0] s);
    return {~s[MSBI], s[MSBI-1:0]};
  endfunction

  assign SAMPLE_READY = !fifo_full && !RESET;
  assign push         = SAMPLE_VALID && SAMPLE_READY;
  assign wr_pair      = '{l: SAMPLE_L, r: SAMPLE_R};
  assign div_zero     = (div == '0);

  stereo_sample_fifo #(.W(2*(MSBI+1)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .wdata (wr_pair),
    .pop   (pop),
    .rdata (rd_pair),
    .level (FIFO_LEVEL),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK)
    if (RESET) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    underrun_set = 1'b0;
`ifdef DAC_SOFT_MUTE_EN
    ramp_tick    = 1'b0;
`endif
    case (state)
      IDLE:  if (ENABLE) state_nxt = PRIME;
      PRIME: if (!ENABLE) state_nxt = OFF;
             else if (FIFO_LEVEL >= HALF) state_nxt = RUN;
      RUN: begin
        // Disabling drops any tick due this cycle.
        if (!ENABLE) state_nxt = OFF;
        else if (div_zero) begin
          if (fifo_empty) begin
            underrun_set = 1'b1;
            state_nxt    = PRIME;
          end else pop = 1'b1;
        end
      end
`ifdef DAC_SOFT_MUTE_EN
      RAMP: begin
        if (ENABLE) state_nxt = PRIME;
        else if (DAC_L == MID && DAC_R == MID) state_nxt = IDLE;
        else ramp_tick = div_zero;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // RATE_DIV is only sampled at reload; PRIME parks at 0 so RUN ticks on entry.
  always_ff @(posedge CLK)
    if (RESET) div <= '0;
    else if (state == RUN || state == RAMP) div <= div_zero ? RATE_DIV : div - 1'b1;
    else div <= '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DAC_L         <= MID;
      DAC_R         <= MID;
      SAMPLE_STROBE <= 1'b0;
    end else begin
      SAMPLE_STROBE <= pop;
      if (pop) begin
        DAC_L <= excess(rd_pair.l);
        DAC_R <= excess(rd_pair.r);
      end
`ifdef DAC_SOFT_MUTE_EN
      else if (ramp_tick) begin
        DAC_L <= ramp_step(DAC_L);
        DAC_R <= ramp_step(DAC_R);
      end
`else
      else if (state == IDLE || !ENABLE) begin
        DAC_L <= MID;
        DAC_R <= MID;
      end
`endif
    end
  end

  always_ff @(posedge CLK)
    if (RESET)             UNDERRUN <= 1'b0;
    else if (underrun_set) UNDERRUN <= 1'b1;
    else if (UNDERRUN_CLR) UNDERRUN <= 1'b0;

endmodule

// File: tb/tb_sigma_delta_sample_sequencer.sv
// Directed bench for sigma_delta_sample_sequencer; soft-mute checks follow DAC_SOFT_MUTE_EN.
module tb_sigma_delta_sample_sequencer;
  logic        CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0, SAMPLE_VALID = 1'b0, UNDERRUN_CLR = 1'b0;
  logic [11:0] RATE_DIV = '0;
  logic [15:0] SAMPLE_L = '0, SAMPLE_R = '0;
  logic        SAMPLE_READY, SAMPLE_STROBE, UNDERRUN;
  logic [15:0] DAC_L, DAC_R;
  logic [3:0]  FIFO_LEVEL;

  int tests = 0, fails = 0, strobe_cnt = 0, cyc = 0;
  int t_prev = 0, t_now = 0, snap = 0;

  sigma_delta_sample_sequencer dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ENABLE        (ENABLE),
    .RATE_DIV      (RATE_DIV),
    .SAMPLE_L      (SAMPLE_L),
    .SAMPLE_R      (SAMPLE_R),
    .SAMPLE_VALID  (SAMPLE_VALID),
    .SAMPLE_READY  (SAMPLE_READY),
    .DAC_L         (DAC_L),
    .DAC_R         (DAC_R),
    .SAMPLE_STROBE (SAMPLE_STROBE),
    .FIFO_LEVEL    (FIFO_LEVEL),
    .UNDERRUN      (UNDERRUN),
    .UNDERRUN_CLR  (UNDERRUN_CLR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (SAMPLE_STROBE === 1'b1) strobe_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    SAMPLE_L = l; SAMPLE_R = r; SAMPLE_VALID = 1'b1;
    step(1);
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin step(1); n++; end while (SAMPLE_STROBE !== 1'b1 && n < 300);
    chk({tag, "_strobe"}, {31'd0, SAMPLE_STROBE}, 32'd1);
    t_prev = t_now;
    t_now  = cyc;
  endtask

  task automatic wait_mid(input string tag);
    int n = 0;
    while (!(DAC_L === 16'h8000 && DAC_R === 16'h8000) && n < 3000) begin step(1); n++; end
    chk(tag, {DAC_L, DAC_R}, 32'h8000_8000);
    step(2);
  endtask

  initial begin
    // 1: reset and idle
    step(1);
    chk("ready_in_reset", {31'd0, SAMPLE_READY}, 32'd0);
    step(1); RESET = 1'b0; step(3);
    chk("rst_dac", {DAC_L, DAC_R}, 32'h8000_8000);
    chk("rst_ready", {31'd0, SAMPLE_READY}, 32'd1);
    chk("rst_level", {28'd0, FIFO_LEVEL}, 32'd0);
    chk("rst_underrun", {31'd0, UNDERRUN}, 32'd0);
    step(5);
    chk("idle_no_strobe", strobe_cnt, 32'd0);

    // 2: basic conversion, period RATE_DIV+1 = 4
    RATE_DIV = 12'd3;
    push(16'h0000, 16'h0000); push(16'h7FFF, 16'h7FFF);
    push(16'h8000, 16'h8000); push(16'h1234, 16'h1234);
    chk("t2_level", {28'd0, FIFO_LEVEL}, 32'd4);
    ENABLE = 1'b1;
    wait_strobe("t2_p0"); chk("t2_p0", {DAC_L, DAC_R}, 32'h8000_8000);
    wait_strobe("t2_p1"); chk("t2_p1", {DAC_L, DAC_R}, 32'hFFFF_FFFF);
    chk("t2_gap1", t_now - t_prev, 32'd4);
    wait_strobe("t2_p2"); chk("t2_p2", {DAC_L, DAC_R}, 32'h0000_0000);
    chk("t2_gap2", t_now - t_prev, 32'd4);
    wait_strobe("t2_p3"); chk("t2_p3", {DAC_L, DAC_R}, 32'h9234_9234);
    chk("t2_gap3", t_now - t_prev, 32'd4);
    ENABLE = 1'b0;
`ifndef DAC_SOFT_MUTE_EN
    step(1); chk("t2_mute_next", {DAC_L, DAC_R}, 32'h8000_8000);
`endif
    wait_mid("t2_idle");
    chk("t2_no_underrun", {31'd0, UNDERRUN}, 32'd0);

    // 3: fill to full with VALID held, no push while full
    SAMPLE_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      SAMPLE_L = 16'(i * 16'h1111); SAMPLE_R = 16'h7000 + 16'(i) + 16'h8000;
      step(1);
    end
    chk("t3_level_full", {28'd0, FIFO_LEVEL}, 32'd8);
    chk("t3_ready_full", {31'd0, SAMPLE_READY}, 32'd0);
    SAMPLE_L = 16'hDEAD; step(3);
    chk("t3_level_hold", {28'd0, FIFO_LEVEL}, 32'd8);
    SAMPLE_VALID = 1'b0;

    // 4: drain at RATE_DIV=1 into underrun; set beats clear
    RATE_DIV = 12'd1; ENABLE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_strobe("t4_pop");
      chk("t4_dac_l", {16'd0, DAC_L}, {16'd0, 16'(i * 16'h1111) ^ 16'h8000});
      chk("t4_dac_r", {16'd0, DAC_R}, {16'd0, 16'h7000 + 16'(i)});
      if (i > 0) chk("t4_gap", t_now - t_prev, 32'd2);
    end
    step(1); UNDERRUN_CLR = 1'b1; step(1); UNDERRUN_CLR = 1'b0;
    chk("t4_underrun_set_wins", {31'd0, UNDERRUN}, 32'd1);
    chk("t4_hold", {DAC_L, DAC_R}, 32'hF777_7007);
    chk("t4_level", {28'd0, FIFO_LEVEL}, 32'd0);
    snap = strobe_cnt;
    step(1); UNDERRUN_CLR = 1'b1; step(1); UNDERRUN_CLR = 1'b0;
    chk("t4_underrun_clr", {31'd0, UNDERRUN}, 32'd0);
    step(4);
    chk("t4_prime_no_strobe", strobe_cnt - snap, 32'd0);

    // 5: PRIME resumes at half full; RATE_DIV change lands on next period
    RATE_DIV = 12'd3;
    push(16'hA000, 16'h0001); push(16'h0F00, 16'hFFFF);
    push(16'h8001, 16'h7FFE); push(16'h4000, 16'hC000);
    wait_strobe("t5_p0"); chk("t5_p0", {DAC_L, DAC_R}, 32'h2000_8001);
    step(1); RATE_DIV = 12'd9;
    wait_strobe("t5_p1"); chk("t5_p1", {DAC_L, DAC_R}, 32'h8F00_7FFF);
    chk("t5_gap_old", t_now - t_prev, 32'd4);
    wait_strobe("t5_p2"); chk("t5_p2", {DAC_L, DAC_R}, 32'h0001_FFFE);
    chk("t5_gap_new", t_now - t_prev, 32'd10);
    ENABLE = 1'b0; RATE_DIV = 12'd0;
`ifndef DAC_SOFT_MUTE_EN
    step(1); chk("t5_mute_next", {DAC_L, DAC_R}, 32'h8000_8000);
`endif
    wait_mid("t5_idle");
    chk("t5_level", {28'd0, FIFO_LEVEL}, 32'd1);

    // 6: disable from 0xC000/0x4000
    push(16'h1111, 16'h2222); push(16'h3333, 16'h4444); push(16'h5555, 16'h6666);
    chk("t6_level", {28'd0, FIFO_LEVEL}, 32'd4);
    ENABLE = 1'b1;
    wait_strobe("t6_p3"); chk("t6_p3", {DAC_L, DAC_R}, 32'hC000_4000);
    ENABLE = 1'b0;
`ifdef DAC_SOFT_MUTE_EN
    step(2); chk("t6_ramp1", {DAC_L, DAC_R}, 32'hBF00_4100);
    step(1); chk("t6_ramp2", {DAC_L, DAC_R}, 32'hBE00_4200);
    step(61); chk("t6_ramp63", {DAC_L, DAC_R}, 32'h8100_7F00);
    step(1); chk("t6_ramp64", {DAC_L, DAC_R}, 32'h8000_8000);
    step(2);
`else
    step(1); chk("t6_mute_next", {DAC_L, DAC_R}, 32'h8000_8000);
`endif
    chk("t6_level_kept", {28'd0, FIFO_LEVEL}, 32'd3);

    // 7: reset mid-operation flushes FIFO
    ENABLE = 1'b1;
    push(16'h0102, 16'h0304);
    step(1); RESET = 1'b1; ENABLE = 1'b0; step(1);
    chk("t7_rst_level", {28'd0, FIFO_LEVEL}, 32'd0);
    chk("t7_rst_ready", {31'd0, SAMPLE_READY}, 32'd0);
    chk("t7_rst_dac", {DAC_L, DAC_R}, 32'h8000_8000);
    RESET = 1'b0; step(2);
    chk("t7_ready", {31'd0, SAMPLE_READY}, 32'd1);
    push(16'h7000, 16'hFFFF); push(16'h0001, 16'h0002);
    push(16'h0003, 16'h0004); push(16'h0005, 16'h0006);
    ENABLE = 1'b1;
    wait_strobe("t7_first"); chk("t7_first", {DAC_L, DAC_R}, 32'hF000_7FFF);
    ENABLE = 1'b0;
    wait_mid("t7_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
